// File: rtl/rgb_thresh_pkg.sv
// Shared defaults, configuration address map and reset bound values for the RGB threshold classifier.
package rgb_thresh_pkg;

  localparam int DEF_PIX_W       = 10;
  localparam int DEF_NUM_CLASSES = 3;
  localparam int DEF_CNT_W       = 22;
  localparam int MAX_PIX_W       = 10;

  // Class k occupies config words 2k (min) and 2k+1 (max).
  localparam int MIN_OFS = 0;
  localparam int MAX_OFS = 1;

  // min above max means no pixel can land inside the box.
  localparam logic [3*MAX_PIX_W-1:0] BOUND_MIN_RST = '1;
  localparam logic [3*MAX_PIX_W-1:0] BOUND_MAX_RST = '0;

endpackage

// File: rtl/rgb_class_compare.sv
// One colour box: registers the six per-component min/max compares of a pixel (pipeline stage 1).
// Latency 1 cycle; no backpressure.
module rgb_class_compare
  import rgb_thresh_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [3*PIX_W-1:0] i_pix,
  input  logic [3*PIX_W-1:0] i_min,
  input  logic [3*PIX_W-1:0] i_max,
  output logic [5:0]         o_cmp
);

  logic [2:0] w_ge;
  logic [2:0] w_le;
  logic [5:0] r_cmp;

  always_comb begin
    w_ge = '0;
    w_le = '0;
    for (int c = 0; c < 3; c++) begin
      w_ge[c] = i_pix[c*PIX_W +: PIX_W] >= i_min[c*PIX_W +: PIX_W];
      w_le[c] = i_pix[c*PIX_W +: PIX_W] <= i_max[c*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cmp <= '0;
    end else begin
      r_cmp <= {w_le, w_ge};
    end
  end

  assign o_cmp = r_cmp;

endmodule

// File: rtl/rgb_threshold_classifier.sv
// Two-stage RGB box classifier with frame-synchronous threshold commit; latency 2, one pixel/cycle.
// Optional per-class per-frame hit counters under RGB_THRESH_COUNT_EN.
module rgb_threshold_classifier
  import rgb_thresh_pkg::*;
#(
  parameter  int PIX_W       = DEF_PIX_W,
  parameter  int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int ADDR_W      = $clog2(2*NUM_CLASSES)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [PIX_W-1:0]             in_red,
  input  logic [PIX_W-1:0]             in_green,
  input  logic [PIX_W-1:0]             in_blue,
  input  logic                         in_valid,
  input  logic                         in_frame_start,
  input  logic                         in_frame_end,
  input  logic                         cfg_wr,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [3*PIX_W-1:0]           cfg_wrdata,
  input  logic                         cfg_commit,
  output logic                         cfg_pending,
  output logic [NUM_CLASSES-1:0]       out_class,
  output logic                         out_any,
  output logic                         out_valid,
  output logic                         out_frame_start,
  output logic                         out_frame_end,
  output logic [NUM_CLASSES*CNT_W-1:0] out_count,
  output logic                         out_count_valid
);

  localparam int BW = 3*PIX_W;

  logic [BW-1:0] r_shadow_min [NUM_CLASSES];
  logic [BW-1:0] r_shadow_max [NUM_CLASSES];
  logic [BW-1:0] r_active_min [NUM_CLASSES];
  logic [BW-1:0] r_active_max [NUM_CLASSES];
  logic [BW-1:0] w_shadow_min_nxt [NUM_CLASSES];
  logic [BW-1:0] w_shadow_max_nxt [NUM_CLASSES];
  logic [BW-1:0] w_active_min_nxt [NUM_CLASSES];
  logic [BW-1:0] w_active_max_nxt [NUM_CLASSES];
  logic [5:0]    w_cmp [NUM_CLASSES];

  logic                   r_pending;
  logic                   w_addr_ok;
  logic                   w_xfer;
  logic                   r_s1_vld;
  logic                   r_s1_fs;
  logic                   r_s1_fe;
  logic [NUM_CLASSES-1:0] w_hit;

  assign w_addr_ok = int'(cfg_addr) < 2*NUM_CLASSES;
  // A commit arriving on the start pixel itself still lands on this frame.
  assign w_xfer    = in_valid & in_frame_start & (r_pending | cfg_commit);

  // Stage-1 compares see the post-transfer set so the start pixel uses the new bounds.
  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      w_shadow_min_nxt[k] = r_shadow_min[k];
      w_shadow_max_nxt[k] = r_shadow_max[k];
      if (cfg_wr && w_addr_ok && cfg_addr == ADDR_W'(2*k + MIN_OFS)) w_shadow_min_nxt[k] = cfg_wrdata;
      if (cfg_wr && w_addr_ok && cfg_addr == ADDR_W'(2*k + MAX_OFS)) w_shadow_max_nxt[k] = cfg_wrdata;
      w_active_min_nxt[k] = w_xfer ? w_shadow_min_nxt[k] : r_active_min[k];
      w_active_max_nxt[k] = w_xfer ? w_shadow_max_nxt[k] : r_active_max[k];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        r_shadow_min[k] <= BOUND_MIN_RST[BW-1:0];
        r_shadow_max[k] <= BOUND_MAX_RST[BW-1:0];
        r_active_min[k] <= BOUND_MIN_RST[BW-1:0];
        r_active_max[k] <= BOUND_MAX_RST[BW-1:0];
      end
      r_pending <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        r_shadow_min[k] <= w_shadow_min_nxt[k];
        r_shadow_max[k] <= w_shadow_max_nxt[k];
        r_active_min[k] <= w_active_min_nxt[k];
        r_active_max[k] <= w_active_max_nxt[k];
      end
      r_pending <= ~w_xfer & (r_pending | cfg_commit);
    end
  end

  assign cfg_pending = r_pending;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_class
    rgb_class_compare #(.PIX_W(PIX_W)) u_cmp (
      .clock   (clock),
      .reset_n (reset_n),
      .i_pix   ({in_red, in_green, in_blue}),
      .i_min   (w_active_min_nxt[k]),
      .i_max   (w_active_max_nxt[k]),
      .o_cmp   (w_cmp[k])
    );
    assign w_hit[k] = r_s1_vld & (&w_cmp[k]);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1_vld        <= 1'b0;
      r_s1_fs         <= 1'b0;
      r_s1_fe         <= 1'b0;
      out_class       <= '0;
      out_any         <= 1'b0;
      out_valid       <= 1'b0;
      out_frame_start <= 1'b0;
      out_frame_end   <= 1'b0;
    end else begin
      r_s1_vld        <= in_valid;
      r_s1_fs         <= in_valid & in_frame_start;
      r_s1_fe         <= in_valid & in_frame_end;
      out_class       <= w_hit;
      out_any         <= |w_hit;
      out_valid       <= r_s1_vld;
      out_frame_start <= r_s1_fs;
      out_frame_end   <= r_s1_fe;
    end
  end

`ifdef RGB_THRESH_COUNT_EN
  logic [CNT_W-1:0]             r_cnt [NUM_CLASSES];
  logic [CNT_W-1:0]             w_cnt_nxt [NUM_CLASSES];
  logic [NUM_CLASSES*CNT_W-1:0] r_count;
  logic                         r_count_vld;

  // Counting happens at stage 2 so the report lines up with out_frame_end.
  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      w_cnt_nxt[k] = r_s1_fs ? '0 : r_cnt[k];
      if (w_hit[k] && w_cnt_nxt[k] != {CNT_W{1'b1}}) w_cnt_nxt[k] = w_cnt_nxt[k] + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CLASSES; k++) r_cnt[k] <= '0;
      r_count     <= '0;
      r_count_vld <= 1'b0;
    end else begin
      if (r_s1_vld) begin
        for (int k = 0; k < NUM_CLASSES; k++) r_cnt[k] <= w_cnt_nxt[k];
      end
      if (r_s1_fe) begin
        for (int k = 0; k < NUM_CLASSES; k++) r_count[k*CNT_W +: CNT_W] <= w_cnt_nxt[k];
      end
      r_count_vld <= r_s1_fe;
    end
  end

  assign out_count       = r_count;
  assign out_count_valid = r_count_vld;
`else
  assign out_count       = '0;
  assign out_count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_threshold_classifier.sv
// Directed plus randomized bench for rgb_threshold_classifier against a frame-level behavioural model.
module tb_rgb_threshold_classifier;

  localparam int PW = 10;
  localparam int NC = 3;
`ifdef RGB_THRESH_COUNT_EN
  localparam int CW = 4;
  localparam bit CNT_EN = 1'b1;
`else
  localparam int CW = 22;
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int AW = $clog2(2*NC);

  logic              clock;
  logic              reset_n;
  logic [PW-1:0]     in_red, in_green, in_blue;
  logic              in_valid, in_frame_start, in_frame_end;
  logic              cfg_wr;
  logic [AW-1:0]     cfg_addr;
  logic [3*PW-1:0]   cfg_wrdata;
  logic              cfg_commit;
  logic              cfg_pending;
  logic [NC-1:0]     out_class;
  logic              out_any, out_valid, out_frame_start, out_frame_end;
  logic [NC*CW-1:0]  out_count;
  logic              out_count_valid;

  rgb_threshold_classifier #(.PIX_W(PW), .NUM_CLASSES(NC), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .in_valid(in_valid), .in_frame_start(in_frame_start), .in_frame_end(in_frame_end),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wrdata(cfg_wrdata), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending),
    .out_class(out_class), .out_any(out_any), .out_valid(out_valid),
    .out_frame_start(out_frame_start), .out_frame_end(out_frame_end),
    .out_count(out_count), .out_count_valid(out_count_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic          vld, fs, fe;
    logic [NC-1:0] cls;
    logic          cv;
    logic [NC*CW-1:0] cnts;
  } ent_t;

  int   sh_min [NC][3], sh_max [NC][3], ac_min [NC][3], ac_max [NC][3];
  int   m_cnt  [NC];
  bit   m_pend;
  ent_t m_s1, m_out;
  logic [NC*CW-1:0] m_out_count;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      for (int c = 0; c < 3; c++) begin
        sh_min[k][c] = (1 << PW) - 1; sh_max[k][c] = 0;
        ac_min[k][c] = (1 << PW) - 1; ac_max[k][c] = 0;
      end
      m_cnt[k] = 0;
    end
    m_pend = 1'b0; m_s1 = '0; m_out = '0; m_out_count = '0;
  endtask

  // Advance one clock: update the model from the inputs present now, then compare after the edge.
  task automatic cycle();
    ent_t e;
    bit   xfer, hit;
    int   p [3];
    longint mx;
    mx = (longint'(1) << CW) - 1;
    if (!reset_n) begin
      model_reset();
    end else begin
      e = '0;
      if (cfg_wr && int'(cfg_addr) < 2*NC) begin
        for (int c = 0; c < 3; c++) begin
          if (cfg_addr[0] == 1'b0) sh_min[int'(cfg_addr)/2][c] = int'(cfg_wrdata[(2-c)*PW +: PW]);
          else                     sh_max[int'(cfg_addr)/2][c] = int'(cfg_wrdata[(2-c)*PW +: PW]);
        end
      end
      xfer = in_valid && in_frame_start && (m_pend || cfg_commit);
      if (xfer) begin
        ac_min = sh_min;
        ac_max = sh_max;
      end
      m_pend = !xfer && (m_pend || cfg_commit);
      if (in_valid) begin
        p[0] = int'(in_red); p[1] = int'(in_green); p[2] = int'(in_blue);
        e.vld = 1'b1; e.fs = in_frame_start; e.fe = in_frame_end;
        if (in_frame_start) for (int k = 0; k < NC; k++) m_cnt[k] = 0;
        for (int k = 0; k < NC; k++) begin
          hit = 1'b1;
          for (int c = 0; c < 3; c++) if (p[c] < ac_min[k][c] || p[c] > ac_max[k][c]) hit = 1'b0;
          e.cls[k] = hit;
          if (hit) m_cnt[k]++;
        end
        if (CNT_EN && in_frame_end) begin
          e.cv = 1'b1;
          for (int k = 0; k < NC; k++) e.cnts[k*CW +: CW] = CW'(m_cnt[k] > mx ? mx : longint'(m_cnt[k]));
        end
      end
      m_out = m_s1;
      m_s1  = e;
      if (m_out.cv) m_out_count = m_out.cnts;
    end
    @(posedge clock);
    #1;
    cfg_wr = 1'b0; cfg_commit = 1'b0;
    chk("out_valid", out_valid, m_out.vld);
    chk("out_frame_start", out_frame_start, m_out.fs);
    chk("out_frame_end", out_frame_end, m_out.fe);
    chk("out_class", out_class, m_out.cls);
    chk("out_any", out_any, |m_out.cls);
    chk("cfg_pending", cfg_pending, m_pend);
    chk("out_count_valid", out_count_valid, m_out.cv);
    for (int k = 0; k < NC; k++) chk("out_count", out_count[k*CW +: CW], m_out_count[k*CW +: CW]);
  endtask

  task automatic send(input int r, input int g, input int b, input bit fs, input bit fe);
    in_red = PW'(r); in_green = PW'(g); in_blue = PW'(b);
    in_valid = 1'b1; in_frame_start = fs; in_frame_end = fe;
    cycle();
  endtask

  task automatic idle();
    in_valid = 1'b0; in_frame_start = 1'b0; in_frame_end = 1'b0;
    cycle();
  endtask

  task automatic wr(input int a, input int r, input int g, input int b);
    in_valid = 1'b0; in_frame_start = 1'b0; in_frame_end = 1'b0;
    cfg_wr = 1'b1; cfg_addr = AW'(a); cfg_wrdata = {PW'(r), PW'(g), PW'(b)};
    cycle();
  endtask

  initial begin
    reset_n = 1'b0; in_red = '0; in_green = '0; in_blue = '0;
    in_valid = 1'b0; in_frame_start = 1'b0; in_frame_end = 1'b0;
    cfg_wr = 1'b0; cfg_addr = '0; cfg_wrdata = '0; cfg_commit = 1'b0;
    model_reset();

    // Reset state and the no-hit default set.
    cycle(); cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_count_valid", out_count_valid, 0);
    reset_n = 1'b1;
    send(0, 0, 0, 1, 0);
    send(1023, 1023, 1023, 0, 0);
    chk("lat_out_valid", out_valid, 1);
    chk("dflt_class_lo", out_class, 0);
    idle();
    chk("dflt_class_hi", out_class, 0);
    chk("dflt_any_hi", out_any, 0);
    idle();
    chk("lat_valid_drop", out_valid, 0);

    // Program class 0, commit, apply at the frame start.
    wr(0, 405, 0, 0);
    wr(1, 1023, 325, 325);
    cfg_commit = 1'b1; cycle();
    chk("pending_rise", cfg_pending, 1);
    send(500, 100, 100, 1, 0);
    chk("pending_fall", cfg_pending, 0);
    send(404, 100, 100, 0, 0);
    chk("hit_class", out_class, 3'b001);
    chk("hit_any", out_any, 1);
    idle();
    chk("miss_class", out_class, 3'b000);

    // Mid-frame rewrite waits for the next frame start; boundary and overlap hits.
    wr(0, 0, 0, 0);
    wr(1, 499, 325, 325);
    wr(2, 100, 50, 7);
    wr(3, 200, 60, 7);
    wr(4, 200, 60, 7);
    wr(5, 300, 70, 9);
    cfg_commit = 1'b1; cycle();
    send(500, 100, 100, 0, 0);
    chk("midframe_pending", cfg_pending, 1);
    send(200, 60, 7, 1, 0);
    chk("midframe_old_set", out_class, 3'b001);
    chk("commit_applied", cfg_pending, 0);
    send(100, 50, 7, 0, 0);
    chk("overlap_max_min", out_class, 3'b111);
    send(500, 100, 100, 0, 0);
    chk("exact_min", out_class, 3'b011);
    idle();
    chk("new_set_miss", out_class, 3'b000);

    // Twenty class-1 hits in one frame.
    for (int i = 0; i < 20; i++) send(150, 55, 7, i == 0, i == 19);
    idle();
    chk("frame_end_out", out_frame_end, 1);
    if (CNT_EN) begin
      chk("count_valid_pulse", out_count_valid, 1);
      chk("count_c0_sat", out_count[0 +: CW], 15);
      chk("count_c1_sat", out_count[CW +: CW], 15);
      chk("count_c2", out_count[2*CW +: CW], 0);
    end else begin
      chk("count_tied_valid", out_count_valid, 0);
      chk("count_tied", out_count[0 +: CW], 0);
    end
    idle();

    // Reset mid-frame.
    send(150, 55, 7, 1, 0);
    send(150, 55, 7, 0, 0);
    reset_n = 1'b0;
    send(150, 55, 7, 0, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_class", out_class, 0);
    reset_n = 1'b1;
    send(150, 55, 7, 1, 0);
    chk("postrst_flushed", out_valid, 0);
    send(150, 55, 7, 0, 0);
    chk("postrst_valid", out_valid, 1);
    chk("postrst_nohit", out_class, 0);
    idle(); idle();

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      cfg_wr = ($urandom_range(0, 5) == 0);
      cfg_addr = AW'($urandom_range(0, (1 << AW) - 1));
      if (cfg_addr[0] == 1'b0)
        cfg_wrdata = {PW'($urandom_range(0, 600)), PW'($urandom_range(0, 600)), PW'($urandom_range(0, 600))};
      else
        cfg_wrdata = {PW'($urandom_range(300, 1023)), PW'($urandom_range(300, 1023)), PW'($urandom_range(300, 1023))};
      cfg_commit = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_frame_start = ($urandom_range(0, 11) == 0);
      in_frame_end = ($urandom_range(0, 11) == 0);
      in_red = PW'($urandom_range(250, 650));
      in_green = PW'($urandom_range(250, 650));
      in_blue = PW'($urandom_range(250, 650));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/rgb_threshold_classifier.md
# rgb_threshold_classifier

Parametrised, pipelined colour classifier: compares each incoming RGB pixel against NUM_CLASSES programmable min/max boxes and emits one hit bit per class plus their OR. It replaces the fixed three-colour binarizer in the sensor pixel path, between Bayer-to-RGB conversion and the blob/centroid stages. Thresholds are written into shadow registers and only take effect at a frame boundary, so a frame never mixes two threshold sets. Optional per-class pixel counters report a hit count per frame.

## Interface
- PIX_W, 10, bits per colour component (1..10)
- NUM_CLASSES, 3, number of colour boxes (1..8)
- CNT_W, 22, per-class hit counter width
- clock  in  1  pipeline clock
- reset_n  in  1  reset; synchronous, active-low; clock clock
- in_red / in_green / in_blue  in  PIX_W each  pixel components
- in_valid  in  1  pixel qualifier
- in_frame_start  in  1  marks first pixel of frame; ignored unless in_valid
- in_frame_end  in  1  marks last pixel of frame; ignored unless in_valid
- cfg_wr  in  1  shadow write strobe
- cfg_addr  in  $clog2(2*NUM_CLASSES)  word 2k = class k min, 2k+1 = class k max
- cfg_wrdata  in  3*PIX_W  {R,G,B} bound, R in MSBs
- cfg_commit  in  1  request shadow→active transfer at next frame start
- cfg_pending  out  1  commit requested, not yet applied
- out_class  out  NUM_CLASSES  bit k = pixel inside box k
- out_any  out  1  OR of out_class
- out_valid, out_frame_start, out_frame_end  out  1  delayed qualifiers
- out_count  out  NUM_CLASSES*CNT_W  per-class hit counts of last complete frame, class k at [k*CNT_W +: CNT_W]
- out_count_valid  out  1  one-cycle pulse, new out_count

## Operation
- Hit for class k: min_k ≤ component ≤ max_k for all three components, unsigned, inclusive.
- Reset: active and shadow min = all ones, max = 0 (no class can hit); cfg_pending = 0; all outputs 0; counters 0.
- cfg_wr writes shadow word cfg_addr; addresses ≥ 2*NUM_CLASSES ignored. Active set untouched.
- cfg_commit sets cfg_pending. On a cycle with in_valid & in_frame_start & pending, active ← shadow, pending clears; that start pixel is classified with the new set.
- Same-cycle cfg_wr + cfg_commit + frame start: write is included in the transferred set; pending does not remain set.
- cfg_commit while pending: no effect beyond staying pending.
- Frame boundary is the only transfer point; no frame activity → pending indefinitely.
- in_valid low: pipeline advances, out_valid low, out_class/out_any forced 0, counters unchanged.

## Timing
- Two-stage pipeline, latency 2: stage 1 registers the six per-component compares per class, stage 2 ANDs and registers out_class/out_any. out_valid/out_frame_* track the pixel with the same latency.
- Full throughput: one pixel per cycle, no backpressure.
- Reset mid-frame: pipeline flushes on the reset cycle; outputs 0 the following cycle; active thresholds return to no-hit values.
- cfg_pending rises the cycle after cfg_commit, falls the cycle after the transfer.

## Configuration
- RGB_THRESH_COUNT_EN defined: per-class counters present. Counters reset to 0 on the frame_start pixel (counting it), increment per hit, saturate at 2^CNT_W−1. On the frame_end pixel at stage 2, out_count ← final counts (that pixel included), out_count_valid pulses with out_frame_end. frame_start with no preceding frame_end: counters restart, no report. Frame of one pixel (start & end together) reports that pixel only.
- Undefined: no counter logic; out_count tied 0, out_count_valid tied 0.

## Structure
- Package rgb_thresh_pkg: default PIX_W, NUM_CLASSES, CNT_W; address-map constants (MIN/MAX word offsets); reset bound values.
- Sub-module rgb_class_compare: one class box, stage-1 registered compares; generated NUM_CLASSES times.

## Test plan
- After reset, stream pixels (0,0,0) and (1023,1023,1023) → out_class = 0, out_any = 0, out_valid two cycles after in_valid.
- Program class 0 = [405..1023, 0..325, 0..325], commit, frame start with pixel (500,100,100) → out_class = 3'b001, out_any = 1 at cycle +2; (404,100,100) → 0.
- Rewrite class 0 mid-frame and commit → classification unchanged until next in_frame_start; that start pixel uses new bounds; cfg_pending 1 → 0.
- Boundary: pixel exactly equal to min and to max of a box → hit; min+max overlap of two classes → both bits set.
- With RGB_THRESH_COUNT_EN, CNT_W=4: 20 hits of class 1 in frame → out_count class 1 = 15 (saturated), out_count_valid pulse coincident with out_frame_end.
- Assert reset_n low for one cycle mid-frame → next-cycle outputs 0, subsequent pixels miss all classes.
